// File: rtl/cube_color_pkg.sv
// rtl/cube_color_pkg.sv - facelet colour codes, palette constants and cell helpers
package cube_color_pkg;

  localparam int FACE_W = 36;

  typedef enum logic [3:0] {
    NONE   = 4'd0,
    WHITE  = 4'd1,
    RED    = 4'd2,
    ORANGE = 4'd3,
    YELLOW = 4'd4,
    GREEN  = 4'd5,
    BLUE   = 4'd6
  } color_code_t;

  // Cell number 0..8, row-major from the top-left facelet.
  typedef logic [3:0] cell_idx_t;

  localparam logic [29:0] RGB_WHITE  = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0] RGB_RED    = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] RGB_ORANGE = {10'h3FF, 10'h200, 10'h000};
  localparam logic [29:0] RGB_YELLOW = {10'h3FF, 10'h3FF, 10'h000};
  localparam logic [29:0] RGB_GREEN  = {10'h000, 10'h3FF, 10'h000};
  localparam logic [29:0] RGB_BLUE   = {10'h000, 10'h000, 10'h3FF};

  function automatic cell_idx_t cell_index(input logic [1:0] row, input logic [1:0] col);
    return cell_idx_t'(4'(row) * 4'd3 + 4'(col));
  endfunction

  // Nibble of a packed face; topleft sits in bits [3:0].
  function automatic logic [3:0] cell_code(input logic [FACE_W-1:0] bank, input cell_idx_t idx);
    return bank[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/cube_palette_lut.sv
// rtl/cube_palette_lut.sv - maps a facelet code to RGB, unknown codes pass the given pixel through
module cube_palette_lut
  import cube_color_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic [9:0] i_r,
  input  logic [9:0] i_g,
  input  logic [9:0] i_b,
  output logic [9:0] o_r,
  output logic [9:0] o_g,
  output logic [9:0] o_b
);

  logic [29:0] w_rgb;

  // Palette lookup; code 0 and 7..15 keep the pass-through pixel.
  always_comb begin
    w_rgb = {i_r, i_g, i_b};
    case (i_code)
      WHITE:   w_rgb = RGB_WHITE;
      RED:     w_rgb = RGB_RED;
      ORANGE:  w_rgb = RGB_ORANGE;
      YELLOW:  w_rgb = RGB_YELLOW;
      GREEN:   w_rgb = RGB_GREEN;
      BLUE:    w_rgb = RGB_BLUE;
      default: w_rgb = {i_r, i_g, i_b};
    endcase
  end

  assign {o_r, o_g, o_b} = w_rgb;

endmodule

// File: rtl/cube_face_painter.sv
// rtl/cube_face_painter.sv - paints a stored 3x3 face over the video stream; optional HIGHLIGHT_BLINK_EN
module cube_face_painter
  import cube_color_pkg::*;
#(
  parameter int GRID_X0 = 375,
  parameter int GRID_Y0 = 225,
  parameter int CELL    = 50
`ifdef HIGHLIGHT_BLINK_EN
  , parameter int BLINK_BIT = 4
`endif
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              pix_en,
  input  logic [9:0]        X,
  input  logic [9:0]        Y,
  input  logic [9:0]        iR,
  input  logic [9:0]        iG,
  input  logic [9:0]        iB,
  input  logic              face_valid,
  output logic              face_ready,
  input  logic [FACE_W-1:0] face_codes,
`ifdef HIGHLIGHT_BLINK_EN
  input  logic [3:0]        sel_cell,
`endif
  output logic [9:0]        oR,
  output logic [9:0]        oG,
  output logic [9:0]        oB,
  output logic              o_in_grid,
  output logic              frame_start
);

  // Cell edges, one bit wider than the coordinates so X0+3*CELL cannot wrap.
  localparam logic [10:0] X_E0 = 11'(GRID_X0);
  localparam logic [10:0] X_E1 = 11'(GRID_X0 + CELL);
  localparam logic [10:0] X_E2 = 11'(GRID_X0 + 2 * CELL);
  localparam logic [10:0] X_E3 = 11'(GRID_X0 + 3 * CELL);
  localparam logic [10:0] Y_E0 = 11'(GRID_Y0);
  localparam logic [10:0] Y_E1 = 11'(GRID_Y0 + CELL);
  localparam logic [10:0] Y_E2 = 11'(GRID_Y0 + 2 * CELL);
  localparam logic [10:0] Y_E3 = 11'(GRID_Y0 + 3 * CELL);

  logic [FACE_W-1:0] r_shadow;
  logic [FACE_W-1:0] r_active;
  logic              r_pending;
  logic              r_face_ready;
`ifdef HIGHLIGHT_BLINK_EN
  logic [5:0]        r_frame_cnt;
  logic              r1_hl;
`endif

  logic [29:0]       r1_rgb;
  logic [1:0]        r1_col;
  logic [1:0]        r1_row;
  logic              r1_in;
  logic              r1_fs;
  logic [29:0]       r_rgb;
  logic              r_in_grid;
  logic              r_frame_start;

  logic [10:0]       w_x;
  logic [10:0]       w_y;
  logic [1:0]        w_col;
  logic [1:0]        w_row;
  logic              w_in_grid;
  logic              w_origin;
  logic              w_frame_edge;
  logic              w_accept;
  logic              w_pending_nxt;
  cell_idx_t         w_idx;
  logic [3:0]        w_code;
  logic [29:0]       w_lut_pass;
  logic [29:0]       w_lut;
  logic [29:0]       w_paint;
  logic [29:0]       w_out;

  assign w_x           = {1'b0, X};
  assign w_y           = {1'b0, Y};
  assign w_origin      = (X == 10'd0) && (Y == 10'd0);
  assign w_frame_edge  = pix_en && w_origin;
  assign w_accept      = face_valid && r_face_ready;
  // An accept only happens with nothing pending, so it never races a promotion.
  assign w_pending_nxt = w_accept ? 1'b1 : (w_frame_edge ? 1'b0 : r_pending);

  // Column/row by comparison against the cell edges.
  always_comb begin
    w_col     = (w_x < X_E1) ? 2'd0 : ((w_x < X_E2) ? 2'd1 : 2'd2);
    w_row     = (w_y < Y_E1) ? 2'd0 : ((w_y < Y_E2) ? 2'd1 : 2'd2);
    w_in_grid = (w_x >= X_E0) && (w_x < X_E3) && (w_y >= Y_E0) && (w_y < Y_E3);
  end

  // Handshake into the shadow bank and promotion to the active bank at frame start.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_face_ready <= 1'b1;
`ifdef HIGHLIGHT_BLINK_EN
      r_frame_cnt  <= 6'd0;
`endif
    end else begin
      if (w_frame_edge && r_pending) begin
        r_active <= r_shadow;
      end
`ifdef HIGHLIGHT_BLINK_EN
      if (w_frame_edge) begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
`endif
      if (w_accept) begin
        r_shadow <= face_codes;
      end
      r_pending    <= w_pending_nxt;
      r_face_ready <= !w_pending_nxt;
    end
  end

  // S1: register the pixel and its grid position.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r1_rgb <= '0;
      r1_col <= 2'd0;
      r1_row <= 2'd0;
      r1_in  <= 1'b0;
      r1_fs  <= 1'b0;
`ifdef HIGHLIGHT_BLINK_EN
      r1_hl  <= 1'b0;
`endif
    end else if (pix_en) begin
      r1_rgb <= {iR, iG, iB};
      r1_col <= w_col;
      r1_row <= w_row;
      r1_in  <= w_in_grid;
      r1_fs  <= w_origin;
`ifdef HIGHLIGHT_BLINK_EN
      // sel_cell >= 9 never matches a real cell index, so it disables the highlight.
      r1_hl  <= r_frame_cnt[BLINK_BIT] && w_in_grid && (sel_cell == cell_index(w_row, w_col));
`endif
    end
  end

  assign w_idx  = cell_index(r1_row, r1_col);
  assign w_code = cell_code(r_active, w_idx);

`ifdef HIGHLIGHT_BLINK_EN
  // A highlighted cell feeds black as pass-through so that inverting it yields white.
  assign w_lut_pass = r1_hl ? 30'd0 : r1_rgb;
  assign w_paint    = r1_hl ? ~w_lut : w_lut;
`else
  assign w_lut_pass = r1_rgb;
  assign w_paint    = w_lut;
`endif

  cube_palette_lut u_palette (
    .i_code (w_code),
    .i_r    (w_lut_pass[29:20]),
    .i_g    (w_lut_pass[19:10]),
    .i_b    (w_lut_pass[9:0]),
    .o_r    (w_lut[29:20]),
    .o_g    (w_lut[19:10]),
    .o_b    (w_lut[9:0])
  );

  assign w_out = r1_in ? w_paint : r1_rgb;

  // S2: register the painted pixel; frame_start pulses once for pixel (0,0).
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_rgb         <= '0;
      r_in_grid     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pix_en && r1_fs;
      if (pix_en) begin
        r_rgb     <= w_out;
        r_in_grid <= r1_in;
      end
    end
  end

  assign {oR, oG, oB} = r_rgb;
  assign o_in_grid    = r_in_grid;
  assign frame_start  = r_frame_start;
  assign face_ready   = r_face_ready;

endmodule
